// File: rtl/inst_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package inst_fetch_pkg;

    localparam int unsigned INST_RAM_WIDTH = 16;
    localparam int unsigned INST_W         = 32;

    typedef enum logic [1:0] {
        S_GAP   = 2'd0,
        S_REQ   = 2'd1,
        S_STALL = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch.sv
// Instruction-RAM read initiator: owns the PC, issues reads, buffers one
// instruction for the core, and handles redirects and read timeouts.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = INST_RAM_WIDTH,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              fetch_en,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              re,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [INST_W-1:0] read_data,
    input  logic              read_finished,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              fetch_err
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              re_q;

    logic accept_c;
    logic space_c;

    assign accept_c = valid_q && inst_ready;
    assign space_c  = !valid_q || accept_c;

    // Next-state logic; redirect outranks everything except a stalled unit.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        err_d     = err_q;

        if (accept_c) begin
            valid_d = 1'b0;
        end

        if (state_q == S_STALL) begin
            state_d = S_STALL;
        end else if (redirect) begin
            pc_d    = redirect_pc & ~ADDR_W'(3);
            state_d = S_GAP;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_GAP: begin
                    if (fetch_en && space_c) begin
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (read_finished) begin
                        inst_d    = read_data;
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                        pc_d      = pc_q + ADDR_W'(4);
                        state_d   = S_GAP;
                        cnt_d     = '0;
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = S_STALL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = S_GAP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= S_GAP;
            pc_q      <= ADDR_W'(RESET_PC);
            cnt_q     <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            re_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            re_q      <= (state_d == S_REQ);
        end
    end

    // PC only moves outside S_REQ, so it doubles as a stable read address.
    assign re         = re_q;
    assign read_addr  = pc_q;
    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign fetch_err  = err_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a negedge-driven instruction RAM model.
module tb_inst_fetch;

    logic        clk;
    logic        clrn;
    logic        fetch_en;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        re;
    logic [15:0] read_addr;
    logic [31:0] read_data;
    logic        read_finished;
    logic        inst_valid;
    logic [31:0] inst;
    logic [15:0] inst_pc;
    logic        inst_ready;
    logic        fetch_err;

    bit ram_mode;
    int tests;
    int fails;

    inst_fetch dut (
        .clk          (clk),
        .clrn         (clrn),
        .fetch_en     (fetch_en),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .re           (re),
        .read_addr    (read_addr),
        .read_data    (read_data),
        .read_finished(read_finished),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_ready   (inst_ready),
        .fetch_err    (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM answers half a cycle after re rises and clears once re is low.
    always @(negedge clk) begin
        read_finished = re && ram_mode;
        read_data     = (re && ram_mode) ? {16'hC0DE, read_addr} : 32'hDEAD_BEEF;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        ram_mode      = 1'b1;
        read_finished = 1'b0;
        read_data     = 32'h0;
        clrn          = 1'b0;
        fetch_en      = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = 16'h0;
        inst_ready    = 1'b1;

        #2;
        check("rst_re",        32'(re),         32'h0);
        check("rst_read_addr", 32'(read_addr),  32'h0);
        check("rst_valid",     32'(inst_valid), 32'h0);
        check("rst_inst",      inst,            32'h0);
        check("rst_inst_pc",   32'(inst_pc),    32'h0);
        check("rst_err",       32'(fetch_err),  32'h0);

        tick();
        tick();
        clrn     = 1'b1;
        fetch_en = 1'b1;

        // Streaming fetch with core always ready
        tick();
        check("s0_re",    32'(re),         32'h1);
        check("s0_addr",  32'(read_addr),  32'h0);
        check("s0_valid", 32'(inst_valid), 32'h0);
        tick();
        check("c0_valid", 32'(inst_valid), 32'h1);
        check("c0_pc",    32'(inst_pc),    32'h0);
        check("c0_inst",  inst,            32'hC0DE_0000);
        check("c0_re",    32'(re),         32'h0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("sk_re",    32'(re),         32'h1);
            check("sk_addr",  32'(read_addr),  32'(4 * k));
            check("sk_valid", 32'(inst_valid), 32'h0);
            tick();
            check("ck_valid", 32'(inst_valid), 32'h1);
            check("ck_pc",    32'(inst_pc),    32'(4 * k));
            check("ck_inst",  inst,            32'hC0DE_0000 + 32'(4 * k));
            check("ck_re",    32'(re),         32'h0);
        end

        // Backpressure: buffer holds, no new request
        inst_ready = 1'b0;
        repeat (6) begin
            tick();
            check("bp_valid", 32'(inst_valid), 32'h1);
            check("bp_pc",    32'(inst_pc),    32'h000C);
            check("bp_inst",  inst,            32'hC0DE_000C);
            check("bp_re",    32'(re),         32'h0);
        end
        inst_ready = 1'b1;
        tick();
        check("bp_rel_re",   32'(re),        32'h1);
        check("bp_rel_addr", 32'(read_addr), 32'h0010);
        tick();
        check("c16_pc", 32'(inst_pc), 32'h0010);

        // Redirect while a read completes: data dropped
        tick();
        check("s20_addr", 32'(read_addr), 32'h0014);
        redirect    = 1'b1;
        redirect_pc = 16'h0023;
        tick();
        check("rd1_valid", 32'(inst_valid), 32'h0);
        check("rd1_re",    32'(re),         32'h0);
        check("rd1_addr",  32'(read_addr),  32'h0020);
        redirect = 1'b0;
        tick();
        check("rd1_req_re",   32'(re),        32'h1);
        check("rd1_req_addr", 32'(read_addr), 32'h0020);
        tick();
        check("rd1_cap_valid", 32'(inst_valid), 32'h1);
        check("rd1_cap_pc",    32'(inst_pc),    32'h0020);
        check("rd1_cap_inst",  inst,            32'hC0DE_0020);

        // Redirect coinciding with accept
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        check("rd2_valid", 32'(inst_valid), 32'h0);
        check("rd2_re",    32'(re),         32'h0);
        check("rd2_addr",  32'(read_addr),  32'h0100);
        redirect = 1'b0;
        tick();
        check("rd2_req_re", 32'(re), 32'h1);
        tick();
        check("rd2_cap_pc",   32'(inst_pc),  32'h0100);
        check("rd2_cap_inst", inst,          32'hC0DE_0100);

        // PC wrap at top of address space
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        check("wr_addr", 32'(read_addr), 32'hFFFC);
        redirect = 1'b0;
        tick();
        check("wr_req_re", 32'(re), 32'h1);
        tick();
        check("wr_cap_pc",   32'(inst_pc), 32'hFFFC);
        check("wr_cap_inst", inst,         32'hC0DE_FFFC);
        tick();
        check("wr_next_re",   32'(re),        32'h1);
        check("wr_next_addr", 32'(read_addr), 32'h0000);

        // Async reset mid-request
        #2;
        clrn = 1'b0;
        #1;
        check("ar_re",      32'(re),         32'h0);
        check("ar_valid",   32'(inst_valid), 32'h0);
        check("ar_inst",    inst,            32'h0);
        check("ar_inst_pc", 32'(inst_pc),    32'h0);

        // Timeout: RAM never answers
        ram_mode = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        tick();
        check("to_re_rise", 32'(re), 32'h1);
        repeat (15) tick();
        check("to_pre_err", 32'(fetch_err), 32'h0);
        check("to_pre_re",  32'(re),        32'h1);
        tick();
        check("to_err",   32'(fetch_err),  32'h1);
        check("to_re",    32'(re),         32'h0);
        check("to_valid", 32'(inst_valid), 32'h0);
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        check("st_rd_re",   32'(re),        32'h0);
        check("st_rd_err",  32'(fetch_err), 32'h1);
        check("st_rd_addr", 32'(read_addr), 32'h0000);
        redirect = 1'b0;
        tick();
        tick();
        check("st_hold_re", 32'(re), 32'h0);

        // Reset clears the sticky error and fetching restarts
        clrn = 1'b0;
        #1;
        check("rc_err", 32'(fetch_err), 32'h0);
        check("rc_re",  32'(re),        32'h0);
        ram_mode = 1'b1;
        @(negedge clk);
        clrn = 1'b1;
        tick();
        check("rc_req_re",   32'(re),        32'h1);
        check("rc_req_addr", 32'(read_addr), 32'h0000);
        tick();
        check("rc_cap_valid", 32'(inst_valid), 32'h1);
        check("rc_cap_pc",    32'(inst_pc),    32'h0000);
        check("rc_cap_inst",  inst,            32'hC0DE_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
